// File: rtl/frame_bank_scheduler_if.sv
// Handshake/status bundle between capture, display timing and the frame bank scheduler.
// Pulses and levels only; no backpressure, every signal is sampled on clk27.
interface frame_bank_scheduler_if #(
    parameter int ADDR_W = 19,
    parameter int CNT_W  = 16
);
    logic              cam_sof;
    logic              cam_eof;
    logic              disp_vsync;
    logic              cam_wr_allow;
    logic [ADDR_W:0]   wr_base;
    logic [ADDR_W:0]   rd_base;
    logic              disp_valid;
    logic              swap_pulse;
    logic [CNT_W-1:0]  drop_cnt;
    logic [CNT_W-1:0]  repeat_cnt;
    logic [CNT_W-1:0]  abort_cnt;

    modport master (
        output cam_sof, cam_eof, disp_vsync,
        input  cam_wr_allow, wr_base, rd_base, disp_valid, swap_pulse,
               drop_cnt, repeat_cnt, abort_cnt
    );

    modport slave (
        input  cam_sof, cam_eof, disp_vsync,
        output cam_wr_allow, wr_base, rd_base, disp_valid, swap_pulse,
               drop_cnt, repeat_cnt, abort_cnt
    );
endinterface

// File: rtl/frame_bank_scheduler.sv
// Ping-pong bank scheduler for camera capture vs 480p display; swaps only at vsync onset.
// Latency: all outputs registered, 1 cycle after the triggering pulse/edge.
// No backpressure: frames arriving with no free bank are dropped. Stats counters need FRAME_STATS_EN.
module frame_bank_scheduler #(
    parameter int ADDR_W = 19,
    parameter int CNT_W  = 16
) (
    input  logic                    clk27,
    input  logic                    reset,
    frame_bank_scheduler_if.slave   fb
);
    typedef enum logic [1:0] {WAIT_SOF, WRITE, FULL} state_t;

    state_t state, state_nx;
    logic   wr_bank, wr_bank_nx;
    logic   rd_bank, rd_bank_nx;
    logic   allow_q, allow_nx;
    logic   valid_q, valid_nx;
    logic   swap_q, swap_nx;
    logic   vsync_q;
    logic   vs_fall;
    logic   do_swap;
    logic   inc_drop, inc_repeat, inc_abort;

    assign vs_fall = vsync_q & ~fb.disp_vsync;

    always_comb begin
        state_nx   = state;
        wr_bank_nx = wr_bank;
        rd_bank_nx = rd_bank;
        valid_nx   = valid_q;
        swap_nx    = 1'b0;
        do_swap    = 1'b0;
        inc_drop   = 1'b0;
        inc_repeat = 1'b0;
        inc_abort  = 1'b0;

        case (state)
            WAIT_SOF: begin
                inc_repeat = vs_fall;
                if (fb.cam_sof)
                    state_nx = WRITE;
            end
            WRITE: begin
                // eof wins over a coincident sof; eof with vsync onset swaps straight away
                if (fb.cam_eof) begin
                    if (vs_fall) begin
                        do_swap  = 1'b1;
                        state_nx = WAIT_SOF;
                    end else begin
                        state_nx = FULL;
                    end
                end else begin
                    inc_abort  = fb.cam_sof;
                    inc_repeat = vs_fall;
                end
            end
            FULL: begin
                if (vs_fall) begin
                    do_swap  = 1'b1;
                    state_nx = fb.cam_sof ? WRITE : WAIT_SOF;
                end else begin
                    inc_drop = fb.cam_sof;
                end
            end
            default: state_nx = WAIT_SOF;
        endcase

        if (do_swap) begin
            rd_bank_nx = wr_bank;
            wr_bank_nx = ~wr_bank;
            valid_nx   = 1'b1;
            swap_nx    = 1'b1;
        end

        allow_nx = (state_nx == WRITE);
    end

    always_ff @(posedge clk27) begin
        if (reset) begin
            state   <= WAIT_SOF;
            wr_bank <= 1'b0;
            rd_bank <= 1'b1;
            allow_q <= 1'b0;
            valid_q <= 1'b0;
            swap_q  <= 1'b0;
            vsync_q <= 1'b1;
        end else begin
            state   <= state_nx;
            wr_bank <= wr_bank_nx;
            rd_bank <= rd_bank_nx;
            allow_q <= allow_nx;
            valid_q <= valid_nx;
            swap_q  <= swap_nx;
            vsync_q <= fb.disp_vsync;
        end
    end

    assign fb.cam_wr_allow = allow_q;
    assign fb.wr_base      = {wr_bank, {ADDR_W{1'b0}}};
    assign fb.rd_base      = {rd_bank, {ADDR_W{1'b0}}};
    assign fb.disp_valid   = valid_q;
    assign fb.swap_pulse   = swap_q;

`ifdef FRAME_STATS_EN
    logic [CNT_W-1:0] drop_q, repeat_q, abort_q;

    // saturating: hold at all-ones instead of wrapping
    always_ff @(posedge clk27) begin
        if (reset) begin
            drop_q   <= '0;
            repeat_q <= '0;
            abort_q  <= '0;
        end else begin
            if (inc_drop && !(&drop_q))
                drop_q <= drop_q + 1'b1;
            if (inc_repeat && !(&repeat_q))
                repeat_q <= repeat_q + 1'b1;
            if (inc_abort && !(&abort_q))
                abort_q <= abort_q + 1'b1;
        end
    end

    assign fb.drop_cnt   = drop_q;
    assign fb.repeat_cnt = repeat_q;
    assign fb.abort_cnt  = abort_q;
`else
    logic unused_stats;
    assign unused_stats  = inc_drop ^ inc_repeat ^ inc_abort;
    assign fb.drop_cnt   = '0;
    assign fb.repeat_cnt = '0;
    assign fb.abort_cnt  = '0;
`endif
endmodule

// File: tb/tb_frame_bank_scheduler.sv
// Bench for frame_bank_scheduler: directed scenarios plus random traffic against a frame-level model.
module tb_frame_bank_scheduler;
    localparam int ADDR_W = 19;
    localparam int CNT_W  = 16;
    localparam int BANK1  = 1 << ADDR_W;
    localparam int SAT    = (1 << CNT_W) - 1;
`ifdef FRAME_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk27 = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    bit   cmp_en = 1'b0;
    int   nswap  = 0;

    frame_bank_scheduler_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) fb();

    frame_bank_scheduler #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk27 (clk27),
        .reset (reset),
        .fb    (fb)
    );

    always #5 clk27 = ~clk27;

    // Frame-level model: a bank is either being filled, holds a finished frame, or is idle.
    bit m_filling, m_ready, m_valid, m_swap, m_allow, m_vsq;
    int m_wr, m_rd, m_drop, m_rep, m_abort;

    function automatic int sat_inc(input int v);
        return (v >= SAT) ? SAT : v + 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk27) begin
        bit vf, swap_now;
        if (reset) begin
            m_filling = 0; m_ready = 0; m_valid = 0; m_swap = 0; m_allow = 0; m_vsq = 1;
            m_wr = 0; m_rd = 1; m_drop = 0; m_rep = 0; m_abort = 0;
        end else begin
            vf       = m_vsq && !fb.disp_vsync;
            m_vsq    = fb.disp_vsync;
            swap_now = 0;
            if (m_ready) begin
                if (vf) begin
                    swap_now  = 1;
                    m_filling = fb.cam_sof;
                end else if (fb.cam_sof) begin
                    m_drop = sat_inc(m_drop);
                end
            end else if (m_filling) begin
                if (fb.cam_eof) begin
                    m_filling = 0;
                    if (vf) swap_now = 1;
                    else    m_ready  = 1;
                end else begin
                    if (fb.cam_sof) m_abort = sat_inc(m_abort);
                    if (vf)         m_rep   = sat_inc(m_rep);
                end
            end else begin
                if (vf)         m_rep     = sat_inc(m_rep);
                if (fb.cam_sof) m_filling = 1;
            end
            if (swap_now) begin
                m_rd    = m_wr;
                m_wr    = 1 - m_wr;
                m_ready = 0;
                m_valid = 1;
            end
            m_swap  = swap_now;
            m_allow = m_filling;
        end
    end

    always @(negedge clk27) begin
        if (cmp_en) begin
            chk("cam_wr_allow", fb.cam_wr_allow, m_allow);
            chk("wr_base",      fb.wr_base,      m_wr * BANK1);
            chk("rd_base",      fb.rd_base,      m_rd * BANK1);
            chk("disp_valid",   fb.disp_valid,   m_valid);
            chk("swap_pulse",   fb.swap_pulse,   m_swap);
            chk("drop_cnt",     fb.drop_cnt,     STATS ? m_drop  : 0);
            chk("repeat_cnt",   fb.repeat_cnt,   STATS ? m_rep   : 0);
            chk("abort_cnt",    fb.abort_cnt,    STATS ? m_abort : 0);
            chk("bank_differ",  fb.wr_base != fb.rd_base, 1);
            if (fb.swap_pulse === 1'b1) nswap++;
        end
    end

    // Inputs applied 2ns after a falling edge, consumed at the next rising edge.
    task automatic step(input logic sof, input logic eof, input logic vs);
        fb.cam_sof    = sof;
        fb.cam_eof    = eof;
        fb.disp_vsync = vs;
        @(negedge clk27);
        #2;
        fb.cam_sof = 1'b0;
        fb.cam_eof = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_allow"}, fb.cam_wr_allow, 0);
        chk({tag, "_wr"},    fb.wr_base,      0);
        chk({tag, "_rd"},    fb.rd_base,      BANK1);
        chk({tag, "_valid"}, fb.disp_valid,   0);
        chk({tag, "_swap"},  fb.swap_pulse,   0);
        chk({tag, "_drop"},  fb.drop_cnt,     0);
        chk({tag, "_rep"},   fb.repeat_cnt,   0);
        chk({tag, "_abort"}, fb.abort_cnt,    0);
    endtask

    int vpos = 0;
    int vper = 50;
    int base_swap;

    initial begin
        reset = 1'b1;
        fb.cam_sof = 1'b0; fb.cam_eof = 1'b0; fb.disp_vsync = 1'b1;
        step(0, 0, 1);
        cmp_en = 1'b1;
        step(0, 0, 1);
        reset = 1'b0;
        check_reset_vals("rst");

        // one frame written then displayed
        step(1, 0, 1);
        for (int i = 0; i < 99; i++) begin
            step(0, 0, 1);
            if (i == 50) chk("t1_allow_mid", fb.cam_wr_allow, 1);
        end
        step(0, 1, 1);
        chk("t1_allow_after_eof", fb.cam_wr_allow, 0);
        step(0, 0, 0);
        chk("t1_swap", fb.swap_pulse, 1);
        chk("t1_rd",   fb.rd_base,    0);
        chk("t1_wr",   fb.wr_base,    BANK1);
        chk("t1_valid", fb.disp_valid, 1);
        step(0, 0, 0);
        chk("t1_swap_once", fb.swap_pulse, 0);
        step(0, 0, 1);

        // frames dropped while a finished frame waits
        step(1, 0, 1);
        for (int i = 0; i < 10; i++) step(0, 0, 1);
        step(0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 1);
            step(0, 0, 1);
        end
        chk("t2_allow", fb.cam_wr_allow, 0);
        chk("t2_drop",  fb.drop_cnt,     STATS ? 3 : 0);
        step(0, 0, 0);
        chk("t2_swap", fb.swap_pulse, 1);
        chk("t2_rd",   fb.rd_base,    BANK1);
        chk("t2_wr",   fb.wr_base,    0);
        step(0, 0, 0);
        step(0, 0, 1);
        step(0, 0, 1);
        chk("t2_allow_idle", fb.cam_wr_allow, 0);

        // two vsync onsets during a write: repeats, no swap
        base_swap = nswap;
        step(1, 0, 1);
        step(0, 0, 0);
        step(0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1);
        step(0, 0, 0);
        step(0, 0, 1);
        step(0, 1, 1);
        chk("t3_repeat",  fb.repeat_cnt,      STATS ? 2 : 0);
        chk("t3_rd",      fb.rd_base,         BANK1);
        chk("t3_noswap",  nswap - base_swap,  0);

        // eof coincident with vsync onset
        step(0, 0, 0);
        step(0, 0, 1);
        step(1, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 1);
        step(0, 1, 0);
        chk("t4_swap",   fb.swap_pulse,   1);
        chk("t4_allow",  fb.cam_wr_allow, 0);
        chk("t4_rd",     fb.rd_base,      BANK1);
        chk("t4_repeat", fb.repeat_cnt,   STATS ? 2 : 0);
        step(0, 0, 0);
        step(0, 0, 1);
        step(1, 0, 1);
        chk("t4_idle_then_write", fb.cam_wr_allow, 1);

        // sof mid-frame restarts the frame
        for (int i = 0; i < 5; i++) step(0, 0, 1);
        step(1, 0, 1);
        chk("t5_abort", fb.abort_cnt,    STATS ? 1 : 0);
        chk("t5_allow", fb.cam_wr_allow, 1);
`ifdef FRAME_STATS_EN
        for (int i = 0; i < 70000; i++) step(1, 0, 1);
        chk("t5_abort_sat", fb.abort_cnt, 16'hFFFF);
`endif
        step(0, 1, 1);

        // random traffic with a free-running vsync
        for (int i = 0; i < 4000; i++) begin
            logic s, e, v;
            s = ($urandom_range(0, 29) == 0);
            e = ($urandom_range(0, 29) == 0);
            reset = ($urandom_range(0, 999) == 0);
            if (vpos == 0) vper = $urandom_range(30, 90);
            v = (vpos >= 6);
            vpos = (vpos + 1 == vper) ? 0 : vpos + 1;
            step(s, e, v);
        end
        reset = 1'b0;

        // reset while a finished frame is waiting
        step(0, 0, 1);
        step(1, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 1);
        step(0, 1, 1);
        chk("t6_full_allow", fb.cam_wr_allow, 0);
        reset = 1'b1;
        step(0, 0, 1);
        check_reset_vals("t6");
        reset = 1'b0;
        step(0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
